// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the architectural fetch PC, issues single-outstanding
// instruction requests and hands {pc, inst} to IF/ID, squashing redirected fetches.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_allowin,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adef
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_CANCEL,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        adef_q, adef_d;

    logic pc_aligned;
    logic req_fire;

    assign pc_aligned = (pc_q[1:0] == 2'b00);
    // Gated by reset so an abandoned request is dropped the instant reset asserts.
    assign inst_req   = cpu_rstn && (state_q == S_REQ) && pc_aligned;
    assign req_fire   = inst_req && inst_addr_ok;
    assign inst_addr  = pc_q;

    assign if_valid = (state_q == S_HOLD);
    assign if_pc    = pc_q;
    assign if_inst  = if_valid ? inst_buf_q : 32'h0;
    assign if_adef  = if_valid && adef_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        pc_d       = pc_q;
        inst_buf_d = inst_buf_q;
        adef_d     = adef_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = req_fire ? S_CANCEL : S_REQ;
                end else if (!pc_aligned) begin
                    adef_d     = 1'b1;
                    inst_buf_d = 32'h0;
                    state_d    = S_HOLD;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        state_d = S_REQ;
                    end else begin
                        inst_buf_d = inst_rdata;
                        adef_d     = 1'b0;
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_CANCEL;
                end
            end
            S_CANCEL: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (inst_data_ok) state_d = S_REQ;
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (id_allowin) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            inst_buf_q <= 32'h0;
            adef_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
            adef_q     <= adef_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level fetch model.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_allowin;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adef;

    fetch_pc_ctrl #(.RESET_PC(RESET_PC)) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rstn      (cpu_rstn),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_allowin    (id_allowin),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_adef       (if_adef)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Fetch model: architectural pc, an optional held instruction and an optional
    // outstanding memory read that may have been squashed by a redirect.
    typedef struct {
        logic [31:0] pc;
        bit          held;
        logic [31:0] inst;
        bit          adef;
        bit          busy;
        bit          squashed;
    } model_t;

    model_t m;

    function automatic bit model_req(input model_t s);
        return !s.held && !s.busy && (s.pc[1:0] == 2'b00);
    endfunction

    task automatic model_reset();
        m.pc = RESET_PC; m.held = 0; m.inst = 0; m.adef = 0; m.busy = 0; m.squashed = 0;
    endtask

    // Memory environment knobs and state
    int          ao_pct = 100;
    int          min_delay = 0;
    int          max_delay = 0;
    bit          force_rd_en = 0;
    logic [31:0] force_rd = 32'h0;
    bit          mem_busy = 0;
    int          mem_delay = 0;
    logic [31:0] mem_addr = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h5a5a0000;
    endfunction

    task automatic check_outputs();
        bit exp_req;
        exp_req = model_req(m);
        check("if_valid", if_valid, m.held);
        check("inst_req", inst_req, exp_req);
        if (exp_req) check("inst_addr", inst_addr, m.pc);
        if (m.held) begin
            check("if_pc", if_pc, m.pc);
            check("if_inst", if_inst, m.inst);
            check("if_adef", if_adef, m.adef);
        end
    endtask

    task automatic run_cycle(input bit redir, input logic [31:0] rpc, input bit allow);
        bit          dok, aok, acc;
        logic [31:0] rd;
        model_t      n;
        dok = mem_busy && (mem_delay == 0);
        rd  = dok ? (force_rd_en ? force_rd : mem_word(mem_addr)) : $urandom;
        aok = !mem_busy && ($urandom_range(99) < ao_pct);
        redirect_valid = redir;
        redirect_pc    = redir ? rpc : $urandom;
        id_allowin     = allow;
        inst_addr_ok   = aok;
        inst_data_ok   = dok;
        inst_rdata     = rd;
        #1;
        acc = inst_req && aok;

        n = m;
        if (m.held) begin
            if (redir) begin n.pc = rpc; n.held = 0; end
            else if (allow) begin n.pc = m.pc + 32'd4; n.held = 0; end
        end else if (m.busy) begin
            if (redir) n.pc = rpc;
            if (dok) begin
                n.busy = 0;
                if (!m.squashed && !redir) begin n.held = 1; n.inst = rd; n.adef = 0; end
            end else if (redir) begin
                n.squashed = 1;
            end
        end else begin
            if (redir) begin
                n.pc = rpc;
                if (model_req(m) && aok) begin n.busy = 1; n.squashed = 1; end
            end else if (m.pc[1:0] != 2'b00) begin
                n.held = 1; n.inst = 0; n.adef = 1;
            end else if (aok) begin
                n.busy = 1; n.squashed = 0;
            end
        end

        if (dok) mem_busy = 0;
        else if (mem_busy) mem_delay--;
        if (acc) begin
            mem_busy  = 1;
            mem_addr  = inst_addr;
            mem_delay = $urandom_range(max_delay, min_delay);
        end

        @(posedge cpu_clk);
        #1;
        m = n;
        check_outputs();
    endtask

    // which: 0 = wait for a held instruction, 1 = wait for a live outstanding fetch
    task automatic wait_phase(input int which, input string tag);
        bit reached = 0;
        for (int i = 0; i < 60; i++) begin
            reached = (which == 0) ? m.held : (m.busy && !m.squashed);
            if (reached) break;
            run_cycle(0, 32'h0, 1);
        end
        check(tag, reached, 1'b1);
    endtask

    task automatic start_fresh_fetch();
        wait_phase(0, "reach_hold");
        run_cycle(0, 32'h0, 1);
        run_cycle(0, 32'h0, 1);
        check("fresh_fetch_waiting", m.busy, 1'b1);
    endtask

    initial begin
        logic [31:0] pcs[$];
        logic [31:0] hold_pc, hold_inst;

        cpu_rstn = 0; redirect_valid = 0; redirect_pc = 0; id_allowin = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
        model_reset();
        #12;
        check("rst_inst_req", inst_req, 1'b0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_if_adef", if_adef, 1'b0);
        @(negedge cpu_clk);
        cpu_rstn = 1;
        #1;
        check_outputs();

        // Back-to-back throughput with an ideal memory
        for (int i = 0; i < 9; i++) begin
            run_cycle(0, 32'h0, 1);
            if (if_valid) pcs.push_back(if_pc);
        end
        check("tput_count", pcs.size(), 3);
        if (pcs.size() == 3) begin
            check("tput_pc0", pcs[0], 32'h1c000000);
            check("tput_pc1", pcs[1], 32'h1c000004);
            check("tput_pc2", pcs[2], 32'h1c000008);
        end

        // ID stalls for 5 cycles while an instruction is held
        wait_phase(0, "stall_hold");
        hold_pc = if_pc; hold_inst = if_inst;
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, 32'h0, 0);
            check("stall_valid", if_valid, 1'b1);
            check("stall_pc", if_pc, hold_pc);
            check("stall_inst", if_inst, hold_inst);
            check("stall_no_req", inst_req, 1'b0);
        end

        // Redirect while waiting: the stale response (0xdeadbeef) must be discarded
        min_delay = 2; max_delay = 2;
        start_fresh_fetch();
        force_rd_en = 1; force_rd = 32'hdeadbeef;
        run_cycle(1, 32'h1c000100, 1);
        run_cycle(0, 32'h0, 1);
        run_cycle(0, 32'h0, 1);
        force_rd_en = 0;
        check("cancel_req", inst_req, 1'b1);
        check("cancel_addr", inst_addr, 32'h1c000100);
        wait_phase(0, "cancel_hold");
        check("cancel_no_deadbeef", if_inst == 32'hdeadbeef, 1'b0);
        check("cancel_pc", if_pc, 32'h1c000100);

        // data_ok and redirect in the same WAIT cycle
        min_delay = 0; max_delay = 0;
        start_fresh_fetch();
        run_cycle(1, 32'h1c000200, 1);
        check("same_no_valid", if_valid, 1'b0);
        check("same_req", inst_req, 1'b1);
        check("same_addr", inst_addr, 32'h1c000200);

        // Redirect beats allowin in HOLD
        wait_phase(0, "hold_redir");
        run_cycle(1, 32'h1c000300, 1);
        check("hold_redir_valid", if_valid, 1'b0);
        check("hold_redir_addr", inst_addr, 32'h1c000300);

        // Misaligned redirect target takes the address-error path
        wait_phase(0, "adef_hold");
        run_cycle(1, 32'h1c000102, 1);
        check("adef_no_req", inst_req, 1'b0);
        run_cycle(0, 32'h0, 0);
        check("adef_valid", if_valid, 1'b1);
        check("adef_flag", if_adef, 1'b1);
        check("adef_pc", if_pc, 32'h1c000102);
        check("adef_inst", if_inst, 32'h0);
        run_cycle(1, 32'h1c000400, 0);

        // PC increment wraps at the top of the address space
        wait_phase(0, "wrap_pre");
        run_cycle(1, 32'hfffffffc, 1);
        wait_phase(0, "wrap_hold");
        check("wrap_pc", if_pc, 32'hfffffffc);
        run_cycle(0, 32'h0, 1);
        check("wrap_addr", inst_addr, 32'h0);

        // Reset asserted mid-fetch
        min_delay = 3; max_delay = 3;
        start_fresh_fetch();
        cpu_rstn = 0;
        #1;
        check("rstwait_req", inst_req, 1'b0);
        check("rstwait_valid", if_valid, 1'b0);
        model_reset();
        mem_busy = 0;
        redirect_valid = 0; inst_addr_ok = 0; inst_data_ok = 0; id_allowin = 0;
        @(negedge cpu_clk);
        cpu_rstn = 1;
        #1;
        check("rstwait_restart_req", inst_req, 1'b1);
        check("rstwait_restart_addr", inst_addr, RESET_PC);

        // Randomized traffic
        ao_pct = 70; min_delay = 0; max_delay = 3;
        for (int i = 0; i < 3000; i++) begin
            bit          rv;
            logic [31:0] tgt;
            rv  = ($urandom_range(99) < 12);
            tgt = RESET_PC + ($urandom_range(63) << 2);
            if ($urandom_range(7) == 0) tgt = tgt + $urandom_range(3, 1);
            run_cycle(rv, tgt, ($urandom_range(99) < 70));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Consumer end of the next-PC interface: takes the EX-stage redirect (`npc` plus `jump_taken`) and owns the architectural fetch PC register.
- Issues instruction-memory requests over an addr_ok/data_ok handshake with at most one request outstanding.
- Delivers {pc, inst} to IF/ID under a valid/allowin handshake.
- Discards in-flight fetches squashed by a redirect.

Parameters:
- RESET_PC, 32'h1c000000, PC value loaded on reset.

Ports:
- cpu_clk  input  1  clock, rising edge.
- cpu_rstn  input  1  asynchronous active-low reset.
- redirect_valid  input  1  jump_taken from the NPC unit; redirect fetch this cycle.
- redirect_pc  input  32  npc from the NPC unit; sampled only when redirect_valid=1.
- id_allowin  input  1  ID stage accepts the IF output this cycle.
- inst_req  output  1  memory request valid.
- inst_addr  output  32  request address; equals the pc register.
- inst_addr_ok  input  1  request accepted; handshake completes when inst_req & inst_addr_ok.
- inst_data_ok  input  1  read data returned for the oldest accepted request.
- inst_rdata  input  32  instruction word, valid with inst_data_ok.
- if_valid  output  1  IF output valid.
- if_pc  output  32  PC of the delivered instruction.
- if_inst  output  32  delivered instruction word.
- if_adef  output  1  delivered PC is misaligned (pc[1:0]!=0); if_inst=0.

Behaviour:
- Reset (async, cpu_rstn=0):
  - pc=RESET_PC, state=REQ, inst_buf=0, adef=0.
  - Outputs: inst_req=0 during reset; if_valid=0, if_inst=0, if_adef=0.
  - Asserting reset mid-request abandons it; no response is expected afterwards.
- States: REQ, WAIT, CANCEL, HOLD. Priority within each state: redirect_valid first, then everything else.
- REQ (inst_req=1 iff pc[1:0]==0):
  - pc[1:0]!=0 and no redirect: adef<=1, inst_buf<=0, go HOLD; no memory request issued.
  - redirect_valid & !addr_ok: pc<=redirect_pc, stay REQ. The address may change while unaccepted.
  - redirect_valid & addr_ok: pc<=redirect_pc, go CANCEL (the accepted old request must be drained).
  - addr_ok, no redirect: go WAIT.
- WAIT (inst_req=0):
  - data_ok & redirect_valid: drop data, pc<=redirect_pc, go REQ.
  - data_ok only: inst_buf<=inst_rdata, adef<=0, go HOLD.
  - redirect_valid only: pc<=redirect_pc, go CANCEL.
- CANCEL (inst_req=0):
  - Further redirect_valid: pc<=redirect_pc, stay CANCEL unless data_ok in the same cycle.
  - data_ok: discard data, go REQ.
  - Never raises if_valid.
- HOLD (if_valid=1, if_pc=pc, if_inst=inst_buf, if_adef=adef):
  - redirect_valid: pc<=redirect_pc, go REQ; the held instruction is squashed even if id_allowin=1.
  - id_allowin only: pc<=pc+4 (mod 2^32, wraps 0xfffffffc->0), go REQ.
  - Neither: hold all outputs stable.
- if_valid=1 only in HOLD.
- Throughput: minimum 3 cycles per instruction (REQ→WAIT→HOLD) when memory returns data_ok the cycle after addr_ok.
- Memory-side requirement: data_ok is never asserted in REQ or HOLD. A data_ok in those states is a protocol error and is ignored.
- A redirect to a misaligned target passes through REQ, then takes the adef path to HOLD.
- All state and outputs are registered or decoded from state; there are no combinational paths from inst_rdata to the if_* outputs.

Test Plan:
- Reset release, memory with addr_ok=1 and data_ok one cycle later, id_allowin=1:
  - Addresses 0x1c000000, 0x1c000004, 0x1c000008 issued.
  - if_valid pulses every 3 cycles with matching pc/inst.
- id_allowin held 0 for 5 cycles in HOLD:
  - if_valid, if_pc and if_inst stay constant.
  - No new inst_req until allowin=1.
- redirect_valid=1, redirect_pc=0x1c000100 in WAIT:
  - FSM enters CANCEL; the next data_ok (inst 0xdeadbeef) never appears on if_inst.
  - Next inst_addr=0x1c000100.
- Same-cycle data_ok and redirect in WAIT (redirect_pc=0x1c000200):
  - No if_valid.
  - Next request is 0x1c000200.
- Redirect in HOLD with id_allowin=1:
  - The held instruction is squashed; pc=redirect_pc, not pc+4.
- redirect_pc=0x1c000102:
  - No inst_req is raised.
  - if_valid=1, if_adef=1, if_pc=0x1c000102, if_inst=0.
- cpu_rstn asserted while in WAIT:
  - Immediately inst_req=0 and if_valid=0.
  - After release, fetch restarts at RESET_PC.
